// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared constants for the IO-page UART transmitter:
//   - IO page select bit and register offsets (address bits [3:2])
//   - STATUS register bit positions
//   - TX state machine encoding
// -----------------------------------------------------------------------------
package io_pkg;

    // Address bit that selects the IO page on the core bus.
    localparam int IO_PAGE_BIT = 22;

    // Register offsets, taken from address bits [3:2].
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    // STATUS register layout.
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_W   = 7;

    // Serial frame: 8 data bits, LSB first.
    localparam logic [2:0] LAST_BIT_IDX = 3'd7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage : io_pkg

// File: rtl/io_uart_tx_if.sv
// -----------------------------------------------------------------------------
// io_uart_tx_if
// Core IO bus as seen by IO-page peripherals.
//   IO_mem_addr  : byte address from the core
//   IO_mem_wdata : write data from the core
//   IO_mem_wr    : one-cycle write strobe
//   IO_mem_rdata : registered read data back to the core
// Modports: master (core side), slave (peripheral side).
// -----------------------------------------------------------------------------
interface io_uart_tx_if;

    logic [31:0] IO_mem_addr;
    logic [31:0] IO_mem_wdata;
    logic        IO_mem_wr;
    logic [31:0] IO_mem_rdata;

    modport master (
        output IO_mem_addr,
        output IO_mem_wdata,
        output IO_mem_wr,
        input  IO_mem_rdata
    );

    modport slave (
        input  IO_mem_addr,
        input  IO_mem_wdata,
        input  IO_mem_wr,
        output IO_mem_rdata
    );

endinterface : io_uart_tx_if

// File: rtl/io_fifo.sv
// -----------------------------------------------------------------------------
// io_fifo
// Synchronous circular-buffer FIFO.
//   clk, reset : clock, synchronous active-high reset
//   push_i     : write request; accepted when not full or when popping
//   wdata_i    : write data
//   pop_i      : read request; ignored when empty
//   rdata_o    : head entry (valid while !empty_o)
//   full_o     : count == DEPTH
//   empty_o    : count == 0
//   count_o    : number of stored entries ($clog2(DEPTH)+1 bits)
// -----------------------------------------------------------------------------
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        do_push  = push_i && (!full_o || pop_i);
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly AW bits wide, so they wrap without a compare.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule : io_fifo

// File: rtl/io_uart_tx.sv
// -----------------------------------------------------------------------------
// io_uart_tx
// Memory-mapped 8N1 UART transmitter on the core IO page.
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : io_uart_tx_if.slave (IO_mem_addr/wdata/wr in, IO_mem_rdata out)
//   uart_tx: serial output, idle high, driven from a flop
// Registers (address bits [3:2], block selected by address bit 22):
//   0 DATA   : write pushes wdata[7:0] into the TX FIFO; reads 0
//   1 STATUS : {count[14:8], ovf[3], busy[2], full[1], empty[0]}; W1C on bit 3
//   2 DIV    : 16-bit divisor when IO_UART_DIV_REG_EN is defined, else reads 0
//   3        : reads 0, writes ignored
// Build option: define IO_UART_DIV_REG_EN for a writable baud divisor.
// -----------------------------------------------------------------------------
module io_uart_tx
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic         clk,
    input  logic         reset,
    io_uart_tx_if.slave  bus,
    output logic         uart_tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- bus decode ----------------
    logic       sel;
    logic [1:0] off;
    logic       wr_data;
    logic       wr_status;
    logic       wr_div;

    assign sel       = bus.IO_mem_addr[IO_PAGE_BIT];
    assign off       = bus.IO_mem_addr[3:2];
    assign wr_data   = sel && bus.IO_mem_wr && (off == OFF_DATA);
    assign wr_status = sel && bus.IO_mem_wr && (off == OFF_STATUS);
    assign wr_div    = sel && bus.IO_mem_wr && (off == OFF_DIV);

    // ---------------- FIFO ----------------
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push_ok;

    // A push into a full FIFO still fits if the FSM frees a slot this cycle.
    assign push_ok = wr_data && (!fifo_full || fifo_pop);

    io_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_ok),
        .wdata_i (bus.IO_mem_wdata[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ---------------- divisor ----------------
    logic [15:0] div_val;

`ifdef IO_UART_DIV_REG_EN
    logic [15:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (wr_div) begin
            // Divisors below 2 cannot produce a full bit period; clamp them.
            div_d = (bus.IO_mem_wdata[15:0] < 16'd2) ? 16'd2 : bus.IO_mem_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) div_q <= 16'(CLKS_PER_BIT);
        else       div_q <= div_d;
    end

    assign div_val = div_q;
`else
    assign div_val = 16'(CLKS_PER_BIT);
`endif

    // ---------------- overflow flag ----------------
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && bus.IO_mem_wdata[STAT_OVF]) ovf_d = 1'b0;
        // Set is evaluated last so it wins over a same-cycle clear.
        if (wr_data && !push_ok)                     ovf_d = 1'b1;
    end

    // ---------------- TX FSM and baud counter ----------------
    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] cur_div_q, cur_div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        baud_end;

    // The divisor is captured on state entry, so a register write never
    // stretches or shortens the bit currently on the line.
    assign baud_end = (baud_q == cur_div_q - 16'd1);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + 16'd1;
        cur_div_d = cur_div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;

        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    state_d   = TX_START;
                    cur_div_d = div_val;
                end
            end
            TX_START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_d     = '0;
                    state_d   = TX_DATA;
                    cur_div_d = div_val;
                end
            end
            TX_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == LAST_BIT_IDX) begin
                        state_d   = TX_STOP;
                        cur_div_d = div_val;
                    end
                end
            end
            TX_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit: no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_rdata;
                        state_d   = TX_START;
                        cur_div_d = div_val;
                    end else begin
                        state_d   = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level follows the next state so uart_tx changes on the same
        // edge as the state, from a flop.
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[bit_d];
            default:  tx_d = 1'b1;
        endcase
    end

    // ---------------- read data ----------------
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = '0;
        if (sel) begin
            case (off)
                OFF_STATUS: begin
                    rdata_d[STAT_EMPTY] = fifo_empty;
                    rdata_d[STAT_FULL]  = fifo_full;
                    rdata_d[STAT_BUSY]  = (state_q != TX_IDLE);
                    rdata_d[STAT_OVF]   = ovf_q;
                    rdata_d[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
                end
`ifdef IO_UART_DIV_REG_EN
                OFF_DIV:  rdata_d[15:0] = div_val;
`endif
                default:  rdata_d = '0;
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            baud_q    <= '0;
            cur_div_q <= 16'(CLKS_PER_BIT);
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            cur_div_q <= cur_div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
        end
    end

    assign uart_tx          = tx_q;
    assign bus.IO_mem_rdata = rdata_q;

    // Bus bits this block never looks at, gathered in one place.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.IO_mem_addr[31:23], bus.IO_mem_addr[21:4],
                               bus.IO_mem_addr[1:0], bus.IO_mem_wdata[31:8], wr_div};

endmodule : io_uart_tx

// File: tb/tb_io_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_io_uart_tx
// Directed bench for io_uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_io_uart_tx;

    localparam int DIV = 4;

    localparam logic [31:0] A_DATA   = 32'h0040_0000;
    localparam logic [31:0] A_STATUS = 32'h0040_0004;
    localparam logic [31:0] A_DIV    = 32'h0040_0008;
    localparam logic [31:0] A_RSVD   = 32'h0040_000C;
    localparam logic [31:0] A_OFFPG  = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    logic uart_tx;
    int   checks   = 0;
    int   failures = 0;

    io_uart_tx_if bus_if ();

    io_uart_tx #(
        .CLKS_PER_BIT (DIV),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One-cycle write strobe; the write lands on the next rising edge.
    // Returns on the falling edge after that rising edge, address left in place.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus_if.IO_mem_addr  = addr;
        bus_if.IO_mem_wdata = data;
        bus_if.IO_mem_wr    = 1'b1;
        @(negedge clk);
        bus_if.IO_mem_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus_if.IO_mem_addr = addr;
        @(negedge clk);
        data = bus_if.IO_mem_rdata;
    endtask

    // Entered on the falling edge right after uart_tx should have dropped for
    // the start bit. Checks every cycle of the 10-bit frame plus the read data
    // once in the middle; returns on the first cycle after the stop bit.
    task automatic expect_frame(input string tag, input logic [7:0] b, input int div,
                                input logic [31:0] exp_rdata);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < div; j++) begin
                check($sformatf("%s_bit%0d_cyc%0d", tag, i, j), {31'd0, uart_tx}, {31'd0, frame[i]});
                if (i == 5 && j == 0) check($sformatf("%s_rdata", tag), bus_if.IO_mem_rdata, exp_rdata);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;

        // ---------------- reset ----------------
        reset               = 1'b1;
        bus_if.IO_mem_addr  = A_DATA;
        bus_if.IO_mem_wdata = '0;
        bus_if.IO_mem_wr    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_rdata", bus_if.IO_mem_rdata, 32'd0);
        reset = 1'b0;
        bus_read(A_STATUS, rd);
        check("reset_status", rd, 32'h0000_0001);

        // ---------------- single frame 0x55 ----------------
        bus_write(A_DATA, 32'h0000_0055);
        check("f55_pre_tx", {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
        expect_frame("f55", 8'h55, DIV, 32'd0);
        check("f55_idle_tx", {31'd0, uart_tx}, 32'd1);
        bus_read(A_STATUS, rd);
        check("f55_status_idle", rd, 32'h0000_0001);

        // ---------------- back-to-back frames ----------------
        bus_write(A_DATA, 32'h0000_00A5);
        bus_write(A_DATA, 32'h0000_003C);
        bus_if.IO_mem_addr = A_STATUS;
        // first byte popped, second still queued: count 1, busy
        expect_frame("fA5", 8'hA5, DIV, 32'h0000_0104);
        // second byte popped at the end of the first stop bit: empty, busy
        expect_frame("f3C", 8'h3C, DIV, 32'h0000_0005);
        check("b2b_idle_tx", {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
        check("b2b_status_idle", bus_if.IO_mem_rdata, 32'h0000_0001);

        // ---------------- overflow ----------------
        for (int i = 0; i < 10; i++) bus_write(A_DATA, 32'h10 + i);
        bus_read(A_STATUS, rd);
        // count 8, overflow, busy, full
        check("ovf_status", rd, 32'h0000_080E);
        bus_write(A_STATUS, 32'h0000_0008);
        bus_read(A_STATUS, rd);
        check("ovf_cleared", rd, 32'h0000_0806);
        // second data bit of byte 0x10 is on the line
        check("ovf_mid_data_tx", {31'd0, uart_tx}, 32'd0);

        // ---------------- reset mid-frame ----------------
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx", {31'd0, uart_tx}, 32'd1);
        check("midrst_rdata", bus_if.IO_mem_rdata, 32'd0);
        reset = 1'b0;
        bus_read(A_STATUS, rd);
        check("midrst_status", rd, 32'h0000_0001);
        for (int i = 0; i < 12 * DIV; i++) begin
            check($sformatf("midrst_quiet%0d", i), {31'd0, uart_tx}, 32'd1);
            @(negedge clk);
        end

        // ---------------- off-page write and reserved offset ----------------
        bus_write(A_OFFPG, 32'h0000_0077);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("offpg_quiet%0d", i), {31'd0, uart_tx}, 32'd1);
            @(negedge clk);
        end
        bus_read(A_STATUS, rd);
        check("offpg_status", rd, 32'h0000_0001);
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        bus_read(A_RSVD, rd);
        check("rsvd_read", rd, 32'd0);
        check("rsvd_tx", {31'd0, uart_tx}, 32'd1);

        // ---------------- divisor register ----------------
`ifdef IO_UART_DIV_REG_EN
        bus_write(A_DIV, 32'd1);
        bus_read(A_DIV, rd);
        check("div_clamp", rd, 32'd2);
        bus_write(A_DIV, 32'd6);
        bus_read(A_DIV, rd);
        check("div_readback", rd, 32'd6);
        bus_write(A_DATA, 32'h0000_0041);
        @(negedge clk);
        expect_frame("f41", 8'h41, 6, 32'd0);
`else
        bus_write(A_DIV, 32'd6);
        bus_read(A_DIV, rd);
        check("div_absent", rd, 32'd0);
        bus_write(A_DATA, 32'h0000_0041);
        @(negedge clk);
        expect_frame("f41", 8'h41, DIV, 32'd0);
`endif
        check("f41_idle_tx", {31'd0, uart_tx}, 32'd1);
        bus_read(A_STATUS, rd);
        check("f41_status_idle", rd, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_io_uart_tx
